// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: serializes bitstream bytes MSB-first into a
// downstream ccff chain and optionally CRC-checks it by recirculating readback.
module ccff_bitstream_loader #(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             prog_clk,
  input  logic             pReset,
  input  logic             start,
  input  logic             verify,
  input  logic             din_valid,
  input  logic [7:0]       din_data,
  output logic             din_ready,
  output logic             ccff_head,
  output logic             ccff_shift_en,
  input  logic             ccff_tail,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

  function automatic logic [7:0] crc8_step(input logic [7:0] i_crc, input logic i_bit);
    logic fb;
    fb = i_crc[7] ^ i_bit;
    return {i_crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  state_t           r_state;
  logic             r_verify;
  logic [7:0]       r_byte;
  logic [2:0]       r_rem;
  logic             r_head;
  logic             r_shift_en;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_bit_count;
  logic [7:0]       r_crc_tx;
  logic [7:0]       r_crc_rx;

  logic             w_accept;
  logic [CNT_W-1:0] w_left;
  logic [CNT_W-1:0] w_count_inc;
  logic [7:0]       w_crc_rx_next;

  assign w_accept      = din_valid & r_ready;
  assign w_left        = LEN - r_bit_count;
  assign w_count_inc   = (r_bit_count == LEN) ? LEN : r_bit_count + CNT_W'(1);
  assign w_crc_rx_next = crc8_step(r_crc_rx, ccff_tail);

  // r_head/r_shift_en hold the bit being presented this cycle; r_rem counts
  // bits still waiting in r_byte behind it.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state     <= S_IDLE;
      r_verify    <= 1'b0;
      r_byte      <= 8'h00;
      r_rem       <= 3'd0;
      r_head      <= 1'b0;
      r_shift_en  <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_bit_count <= '0;
      r_crc_tx    <= 8'h00;
      r_crc_rx    <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_verify    <= verify;
            r_bit_count <= '0;
            r_err       <= 1'b0;
            r_crc_tx    <= 8'h00;
            r_crc_rx    <= 8'h00;
            r_byte      <= 8'h00;
            r_rem       <= 3'd0;
            r_busy      <= 1'b1;
            r_ready     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (r_shift_en) begin
            r_bit_count <= w_count_inc;
            r_crc_tx    <= crc8_step(r_crc_tx, r_head);
          end
          if (r_bit_count == LEN) begin
            r_ready    <= 1'b0;
            r_head     <= 1'b0;
            if (r_verify) begin
              r_state     <= S_VERIFY;
              r_bit_count <= '0;
              r_shift_en  <= 1'b1;
            end else begin
              r_state    <= S_DONE;
              r_shift_en <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end
          end else if (r_rem != 3'd0) begin
            r_head     <= r_byte[7];
            r_byte     <= {r_byte[6:0], 1'b0};
            r_rem      <= r_rem - 3'd1;
            r_shift_en <= 1'b1;
          end else if (w_accept) begin
            // Only the bits that still fit in the chain are queued.
            r_head     <= din_data[7];
            r_byte     <= {din_data[6:0], 1'b0};
            r_rem      <= (w_left >= CNT_W'(8)) ? 3'd7 : 3'(w_left - CNT_W'(1));
            r_shift_en <= 1'b1;
            r_ready    <= 1'b0;
          end else begin
            r_head     <= 1'b0;
            r_shift_en <= 1'b0;
            if (r_shift_en) begin
              r_ready <= (w_count_inc != LEN);
            end
          end
        end
        S_VERIFY: begin
          r_bit_count <= w_count_inc;
          r_crc_rx    <= w_crc_rx_next;
          if (w_count_inc == LEN) begin
            r_state    <= S_DONE;
            r_shift_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_err      <= (w_crc_rx_next != r_crc_tx);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Readback must recirculate the tail bit in the same cycle, so head bypasses
  // the register during VERIFY.
  assign ccff_head     = (r_state == S_VERIFY) ? ccff_tail : r_head;
  assign ccff_shift_en = r_shift_en;
  assign din_ready     = r_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign bit_count     = r_bit_count;

endmodule
